// File: rtl/soc_mem_pkg.sv
// Shared constants for the 512x8 SoC scratch memory and the masters that share it.
package soc_mem_pkg;

  localparam int unsigned AW     = 11;
  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 512;

  localparam int unsigned M_CORE = 0;
  localparam int unsigned M_DMA  = 1;

  // Address lies beyond the implemented words.
  function automatic logic addr_oor(logic [AW-1:0] addr);
    return 32'(addr) >= DEPTH;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Master-side handshake and memory-side port bundle of the scratch-memory arbiter.
interface mem_port_arbiter_if
  import soc_mem_pkg::*;
;
  logic          m0_req, m1_req;
  logic          m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_err, m1_err;
  logic          mem_ena, mem_wea;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dina;
  logic          mem_rstb;
  logic          mem_enb;
  logic [AW-1:0] mem_addrb;
  logic [DW-1:0] mem_doutb;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_doutb,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_err, m1_err,
    output mem_ena, mem_wea, mem_addra, mem_dina, mem_rstb, mem_enb, mem_addrb
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_doutb,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_err, m1_err,
    input  mem_ena, mem_wea, mem_addra, mem_dina, mem_rstb, mem_enb, mem_addrb
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; on a conflict the pointer moves to the loser.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic conflict;

  assign conflict = req[0] & req[1];

  always_comb begin
    gnt = req;
    if (conflict) gnt = ptr_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (conflict) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the dual-port scratch memory between core and DMA: writes on port A, reads on port B,
// round-robin on same-kind conflicts, registered read-valid and error return per master.
module mem_port_arbiter
  import soc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  logic [1:0]    req, we, oor, gnt, arb_req, arb_gnt, wr_gnt, rd_gnt;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          split;
  logic          wsel, rsel;
  logic [1:0]    rd_pend_q, rd_oor_q, err_q;

  assign req          = {bus.m1_req, bus.m0_req};
  assign we           = {bus.m1_we, bus.m0_we};
  assign addr[M_CORE] = bus.m0_addr;
  assign addr[M_DMA]  = bus.m1_addr;
  assign wdata[M_CORE] = bus.m0_wdata;
  assign wdata[M_DMA]  = bus.m1_wdata;
  assign oor          = {addr_oor(bus.m1_addr), addr_oor(bus.m0_addr)};

  // A read and a write from different masters use separate ports and never contend.
  assign split   = req[0] & req[1] & (we[0] ^ we[1]);
  assign arb_req = split ? 2'b00 : req;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .gnt   (arb_gnt)
  );

  assign gnt        = rst_n ? (split ? 2'b11 : arb_gnt) : 2'b00;
  assign bus.m0_gnt = gnt[0];
  assign bus.m1_gnt = gnt[1];
  assign wr_gnt     = gnt & we;
  assign rd_gnt     = gnt & ~we;
  assign wsel       = wr_gnt[1];
  assign rsel       = rd_gnt[1];

  always_comb begin
    bus.mem_ena   = 1'b0;
    bus.mem_wea   = 1'b0;
    bus.mem_addra = '0;
    bus.mem_dina  = '0;
    if ((|wr_gnt) && !oor[wsel]) begin
      bus.mem_ena   = 1'b1;
      bus.mem_wea   = 1'b1;
      bus.mem_addra = addr[wsel];
      bus.mem_dina  = wdata[wsel];
    end
  end

  always_comb begin
    bus.mem_enb   = 1'b0;
    bus.mem_addrb = '0;
    if ((|rd_gnt) && !oor[rsel]) begin
      bus.mem_enb   = 1'b1;
      bus.mem_addrb = addr[rsel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 2'b00;
      rd_oor_q  <= 2'b00;
      err_q     <= 2'b00;
    end else begin
      rd_pend_q <= rd_gnt;
      rd_oor_q  <= rd_gnt & oor;
      err_q     <= gnt & oor;
    end
  end

  assign bus.mem_rstb  = ~rst_n;
  assign bus.m0_rvalid = rd_pend_q[0];
  assign bus.m1_rvalid = rd_pend_q[1];
  assign bus.m0_err    = err_q[0];
  assign bus.m1_err    = err_q[1];
  // Out-of-range reads return zero rather than whatever the memory last produced.
  assign bus.m0_rdata  = (rd_pend_q[0] && !rd_oor_q[0]) ? bus.mem_doutb : '0;
  assign bus.m1_rdata  = (rd_pend_q[1] && !rd_oor_q[1]) ? bus.mem_doutb : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 2048x8 dual-port memory attached.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: registered read, write-to-read forwarding, read-port reset.
  logic [7:0] mem_arr [2048];
  logic [7:0] dout_q;
  assign bus.mem_doutb = dout_q;

  initial begin
    for (int i = 0; i < 2048; i++) mem_arr[i] = 8'h00;
    dout_q = 8'h00;
  end

  always @(posedge clk) begin
    if (bus.mem_rstb) dout_q <= 8'h00;
    else if (bus.mem_enb)
      dout_q <= (bus.mem_ena && bus.mem_wea && bus.mem_addra == bus.mem_addrb) ?
                bus.mem_dina : mem_arr[bus.mem_addrb];
    if (bus.mem_ena && bus.mem_wea) mem_arr[bus.mem_addra] <= bus.mem_dina;
  end

  task automatic drive(input logic r0, input logic w0, input logic [10:0] a0,
                       input logic [7:0] d0, input logic r1, input logic w1,
                       input logic [10:0] a1, input logic [7:0] d1);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 11'h0, 8'h0, 1'b0, 1'b0, 11'h0, 8'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 11'h010, 8'h0, 1'b1, 1'b1, 11'h020, 8'h11);
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b want 00", {bus.m1_gnt, bus.m0_gnt});
    end
    n_tests++;
    if ({bus.mem_ena, bus.mem_wea, bus.mem_enb, bus.mem_rstb} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mem: ena/wea/enb/rstb got %b want 0001",
               {bus.mem_ena, bus.mem_wea, bus.mem_enb, bus.mem_rstb});
    end
    n_tests++;
    if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err, bus.m0_rdata, bus.m1_rdata}
        !== 20'h0) begin
      n_fail++; $display("FAIL reset_ret: rvalid/err/rdata not all zero");
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(1'b1, 1'b1, 11'h010, 8'h5A, 1'b0, 1'b0, 11'h0, 8'h0);
    #1;
    n_tests++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.mem_ena, bus.mem_wea, bus.mem_enb} !== 5'b01110) begin
      n_fail++;
      $display("FAIL wr_strobe: gnt1/gnt0/ena/wea/enb got %b want 01110",
               {bus.m1_gnt, bus.m0_gnt, bus.mem_ena, bus.mem_wea, bus.mem_enb});
    end
    n_tests++;
    if ({bus.mem_addra, bus.mem_dina} !== {11'h010, 8'h5A}) begin
      n_fail++; $display("FAIL wr_bus: addra=%h dina=%h want 010/5a", bus.mem_addra, bus.mem_dina);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err} !== 4'b0000) begin
      n_fail++; $display("FAIL wr_noret: rvalid/err after write got %b want 0000",
                         {bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err});
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 11'h0, 8'h0, 1'b1, 1'b0, 11'h010, 8'h0);
    #1;
    n_tests++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.mem_ena, bus.mem_enb, bus.mem_addrb}
        !== {4'b1001, 11'h010}) begin
      n_fail++; $display("FAIL rd_issue: gnt=%b ena=%b enb=%b addrb=%h want 10/0/1/010",
                         {bus.m1_gnt, bus.m0_gnt}, bus.mem_ena, bus.mem_enb, bus.mem_addrb);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if ({bus.m1_rvalid, bus.m0_rvalid, bus.m1_rdata} !== {2'b10, 8'h5A}) begin
      n_fail++; $display("FAIL rd_return: rvalid1/0=%b rdata1=%h want 10/5a",
                         {bus.m1_rvalid, bus.m0_rvalid}, bus.m1_rdata);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.m1_rvalid, bus.m1_rdata} !== 9'h0) begin
      n_fail++; $display("FAIL rd_single: rvalid1=%b rdata1=%h want 0/00",
                         bus.m1_rvalid, bus.m1_rdata);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    drive(1'b1, 1'b1, 11'h020, 8'h3C, 1'b1, 1'b0, 11'h020, 8'h0);
    #1;
    n_tests++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.mem_ena, bus.mem_wea, bus.mem_enb} !== 5'b11111) begin
      n_fail++; $display("FAIL split_gnt: gnt1/gnt0/ena/wea/enb got %b want 11111",
                         {bus.m1_gnt, bus.m0_gnt, bus.mem_ena, bus.mem_wea, bus.mem_enb});
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if ({bus.m1_rvalid, bus.m1_rdata} !== {1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL split_fwd: rvalid1=%b rdata1=%h want 1/3c",
                         bus.m1_rvalid, bus.m1_rdata);
    end
  endtask

  task automatic test_read_conflict();
    logic [1:0] exp_gnt, prev_gnt;
    prev_gnt = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 11'h010, 8'h0, 1'b1, 1'b0, 11'h020, 8'h0);
      #1;
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_tests++;
      if ({bus.m1_gnt, bus.m0_gnt} !== exp_gnt) begin
        n_fail++; $display("FAIL rdconf_gnt[%0d]: got %b want %b", i,
                           {bus.m1_gnt, bus.m0_gnt}, exp_gnt);
      end
      if (i > 0) begin
        n_tests++;
        if ({bus.m1_rvalid, bus.m0_rvalid} !== prev_gnt ||
            (prev_gnt[0] && bus.m0_rdata !== 8'h5A) || (prev_gnt[1] && bus.m1_rdata !== 8'h3C))
        begin
          n_fail++; $display("FAIL rdconf_ret[%0d]: rvalid=%b rdata0=%h rdata1=%h want %b 5a/3c",
                             i, {bus.m1_rvalid, bus.m0_rvalid}, bus.m0_rdata, bus.m1_rdata,
                             prev_gnt);
        end
      end
      prev_gnt = exp_gnt;
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if ({bus.m1_rvalid, bus.m0_rvalid, bus.m1_rdata} !== {2'b10, 8'h3C}) begin
      n_fail++; $display("FAIL rdconf_last: rvalid=%b rdata1=%h want 10/3c",
                         {bus.m1_rvalid, bus.m0_rvalid}, bus.m1_rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 1'b0, 11'h010, 8'h0, 1'b0, 1'b0, 11'h0, 8'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 11'h020, 8'h0, 1'b0, 1'b0, 11'h0, 8'h0);
    #1;
    n_tests++;
    if ({bus.m0_gnt, bus.m0_rvalid, bus.m0_rdata} !== {2'b11, 8'h5A}) begin
      n_fail++; $display("FAIL b2b_first: gnt0=%b rvalid0=%b rdata0=%h want 1/1/5a",
                         bus.m0_gnt, bus.m0_rvalid, bus.m0_rdata);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if ({bus.m0_rvalid, bus.m0_rdata} !== {1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL b2b_second: rvalid0=%b rdata0=%h want 1/3c",
                         bus.m0_rvalid, bus.m0_rdata);
    end
  endtask

  task automatic test_write_conflict();
    logic [1:0] exp_gnt;
    logic [7:0] exp_din;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 11'h031, 8'hA0 + 8'(i), 1'b1, 1'b1, 11'h030, 8'hB0 + 8'(i));
      #1;
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_din = (i % 2 == 0) ? 8'hA0 + 8'(i) : 8'hB0 + 8'(i);
      n_tests++;
      if ({bus.m1_gnt, bus.m0_gnt} !== exp_gnt || bus.mem_dina !== exp_din ||
          bus.mem_ena !== 1'b1) begin
        n_fail++; $display("FAIL wrconf[%0d]: gnt=%b dina=%h ena=%b want %b %h 1", i,
                           {bus.m1_gnt, bus.m0_gnt}, bus.mem_dina, bus.mem_ena, exp_gnt, exp_din);
      end
    end
    // Read back both addresses; m0 wins the read conflict, m1 keeps requesting.
    @(negedge clk);
    drive(1'b1, 1'b0, 11'h031, 8'h0, 1'b1, 1'b0, 11'h030, 8'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 11'h0, 8'h0, 1'b1, 1'b0, 11'h030, 8'h0);
    #1;
    n_tests++;
    if ({bus.m0_rvalid, bus.m0_rdata, bus.m1_gnt} !== {1'b1, 8'hA2, 1'b1}) begin
      n_fail++; $display("FAIL wrconf_rd031: rvalid0=%b rdata0=%h gnt1=%b want 1/a2/1",
                         bus.m0_rvalid, bus.m0_rdata, bus.m1_gnt);
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if ({bus.m1_rvalid, bus.m1_rdata} !== {1'b1, 8'hB3}) begin
      n_fail++; $display("FAIL wrconf_rd030: rvalid1=%b rdata1=%h want 1/b3",
                         bus.m1_rvalid, bus.m1_rdata);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    drive(1'b1, 1'b1, 11'h7FF, 8'hFF, 1'b1, 1'b0, 11'h200, 8'h0);
    #1;
    n_tests++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.mem_ena, bus.mem_wea, bus.mem_enb} !== 5'b11000) begin
      n_fail++; $display("FAIL oor_strobe: gnt1/gnt0/ena/wea/enb got %b want 11000",
                         {bus.m1_gnt, bus.m0_gnt, bus.mem_ena, bus.mem_wea, bus.mem_enb});
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if ({bus.m1_rvalid, bus.m1_err, bus.m0_err, bus.m0_rvalid} !== 4'b1110 ||
        bus.m1_rdata !== 8'h00) begin
      n_fail++; $display("FAIL oor_ret: rv1/err1/err0/rv0=%b rdata1=%h want 1110/00",
                         {bus.m1_rvalid, bus.m1_err, bus.m0_err, bus.m0_rvalid}, bus.m1_rdata);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.m1_err, bus.m0_err, bus.m1_rvalid} !== 3'b000) begin
      n_fail++; $display("FAIL oor_pulse: err1/err0/rv1 got %b want 000",
                         {bus.m1_err, bus.m0_err, bus.m1_rvalid});
    end
  endtask

  task automatic test_reset_mid_read();
    // Pointer enters favouring m1 from the earlier read-back conflict.
    @(negedge clk);
    drive(1'b1, 1'b0, 11'h010, 8'h0, 1'b1, 1'b0, 11'h020, 8'h0);
    #1;
    n_tests++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL rst_pre_gnt: got %b want 10", {bus.m1_gnt, bus.m0_gnt});
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL rst_pre_gnt2: got %b want 01", {bus.m1_gnt, bus.m0_gnt});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata, bus.m0_gnt, bus.m1_gnt,
         bus.mem_ena, bus.mem_wea, bus.mem_enb, bus.mem_rstb} !== {21'h0, 1'b1}) begin
      n_fail++; $display("FAIL rst_mid: rv0=%b rv1=%b gnt=%b enb=%b rstb=%b want 0/0/00/0/1",
                         bus.m0_rvalid, bus.m1_rvalid, {bus.m1_gnt, bus.m0_gnt},
                         bus.mem_enb, bus.mem_rstb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL rst_ptr: post-reset conflict gnt=%b want 01",
                         {bus.m1_gnt, bus.m0_gnt});
    end
    @(negedge clk);
    idle();
    #1;
    n_tests++;
    if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata} !== {2'b10, 8'h5A}) begin
      n_fail++; $display("FAIL rst_resume: rv0/rv1=%b rdata0=%h want 10/5a",
                         {bus.m0_rvalid, bus.m1_rvalid}, bus.m0_rdata);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_write_read();
    test_same_cycle();
    test_read_conflict();
    test_back_to_back();
    test_write_conflict();
    test_out_of_range();
    test_reset_mid_read();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
